// File: rtl/npu_csr_regs_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : CSR_BUS_SV (interface)                                        |
// | Brief  : Configuration bus between npu_csr_regs and the NPU datapath.  |
// |          The register block drives every configuration field and the  |
// |          one-cycle csr_control start pulse. The datapath drives        |
// |          csr_status (busy).                                            |
// | Ports  : Slave  modport - register block side (drives config).         |
// |          Master modport - datapath side (drives csr_status).           |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
interface CSR_BUS_SV;
  logic                csr_control;
  logic                csr_status;
  logic        [31:0]  csr_addr_t0;
  logic        [31:0]  csr_addr_t1;
  logic        [31:0]  csr_addr_t2;
  // Tensor shape fields: _0 = row, _1 = col, _2 = depth
  logic        [9:0]   csr_addr_t0_0;
  logic        [9:0]   csr_addr_t0_1;
  logic        [5:0]   csr_addr_t0_2;
  logic        [4:0]   csr_addr_t1_0;
  logic        [4:0]   csr_addr_t1_1;
  logic        [5:0]   csr_addr_t1_2;
  logic        [9:0]   csr_addr_t2_0;
  logic        [9:0]   csr_addr_t2_1;
  logic        [10:0]  csr_addr_t2_2;
  logic signed [7:0]   csr_zp_t0;
  logic signed [7:0]   csr_zp_t1;
  logic signed [7:0]   csr_zp_t2;
  logic signed [31:0]  csr_bias_t2;
  logic signed [31:0]  csr_scale_t2;
  logic        [4:0]   csr_shift_t2;

  modport Slave (
    output csr_control, csr_addr_t0, csr_addr_t1, csr_addr_t2,
           csr_addr_t0_0, csr_addr_t0_1, csr_addr_t0_2,
           csr_addr_t1_0, csr_addr_t1_1, csr_addr_t1_2,
           csr_addr_t2_0, csr_addr_t2_1, csr_addr_t2_2,
           csr_zp_t0, csr_zp_t1, csr_zp_t2,
           csr_bias_t2, csr_scale_t2, csr_shift_t2,
    input  csr_status
  );

  modport Master (
    input  csr_control, csr_addr_t0, csr_addr_t1, csr_addr_t2,
           csr_addr_t0_0, csr_addr_t0_1, csr_addr_t0_2,
           csr_addr_t1_0, csr_addr_t1_1, csr_addr_t1_2,
           csr_addr_t2_0, csr_addr_t2_1, csr_addr_t2_2,
           csr_zp_t0, csr_zp_t1, csr_zp_t2,
           csr_bias_t2, csr_scale_t2, csr_shift_t2,
    output csr_status
  );
endinterface
`default_nettype wire

// File: rtl/npu_csr_regs.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : npu_csr_regs                                                  |
// | Brief  : APB3 slave holding the NPU configuration registers. Every     |
// |          transfer takes one wait state; the write commits on the       |
// |          ACCESS->RESP edge and pready is high for exactly one cycle.   |
// | Ports  : clk, rst            - clock, synchronous active-high reset    |
// |          psel/penable/pwrite - APB3 control                            |
// |          paddr/pwdata        - APB3 address / write data               |
// |          prdata/pready/pslverr - APB3 response (registered)            |
// |          csr                 - configuration bus (Slave side)          |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module npu_csr_regs #(
  parameter int unsigned        APB_A_W   = 32,
  parameter logic [APB_A_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [APB_A_W-1:0] paddr,
  input  logic [APB_A_W-1:0] pwdata,
  output logic [APB_A_W-1:0] prdata,
  output logic               pready,
  output logic               pslverr,
  CSR_BUS_SV.Slave           csr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } apb_state_e;

  localparam logic [7:0] c_off_control  = 8'h00;
  localparam logic [7:0] c_off_status   = 8'h04;
  localparam logic [7:0] c_off_addr_t0  = 8'h08;
  localparam logic [7:0] c_off_addr_t1  = 8'h0C;
  localparam logic [7:0] c_off_addr_t2  = 8'h10;
  localparam logic [7:0] c_off_size_t0  = 8'h14;
  localparam logic [7:0] c_off_size_t1  = 8'h18;
  localparam logic [7:0] c_off_size_t2  = 8'h1C;
  localparam logic [7:0] c_off_zp       = 8'h20;
  localparam logic [7:0] c_off_bias_t2  = 8'h24;
  localparam logic [7:0] c_off_scale_t2 = 8'h28;
  localparam logic [7:0] c_off_shift_t2 = 8'h2C;

  // Flops
  apb_state_e         state_q,       state_d;
  logic               pready_q,      pready_d;
  logic               pslverr_q,     pslverr_d;
  logic [APB_A_W-1:0] prdata_q,      prdata_d;
  logic               control_q,     control_d;
  logic               done_q,        done_d;
  logic               status_prev_q, status_prev_d;
  logic [31:0]        addr_t0_q,     addr_t0_d;
  logic [31:0]        addr_t1_q,     addr_t1_d;
  logic [31:0]        addr_t2_q,     addr_t2_d;
  logic [25:0]        size_t0_q,     size_t0_d;
  logic [15:0]        size_t1_q,     size_t1_d;
  logic [30:0]        size_t2_q,     size_t2_d;
  logic [23:0]        zp_q,          zp_d;
  logic [31:0]        bias_t2_q,     bias_t2_d;
  logic [31:0]        scale_t2_q,    scale_t2_d;
  logic [4:0]         shift_t2_q,    shift_t2_d;

  // Decode
  logic [7:0]  w_off;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic        w_busy;
  logic        w_mapped;
  logic        w_is_ctrl;
  logic        w_is_status;
  logic        w_is_cfg;
  logic        w_err;
  logic        w_commit;
  logic        w_wr_ok;
  logic        w_start;
  logic        w_done_set;
  logic        w_done_clr;
  logic        unused_ok;

  // Only the low byte of the address selects a register; the block is
  // assumed to be placed by the interconnect, so BASE_ADDR is informational.
  assign w_off       = paddr[7:0];
  assign w_wdata     = pwdata[31:0];
  assign w_busy      = csr.csr_status;
  assign w_mapped    = (w_off[1:0] == 2'b00) && (w_off <= c_off_shift_t2);
  assign w_is_ctrl   = (w_off == c_off_control);
  assign w_is_status = (w_off == c_off_status);
  assign w_is_cfg    = (w_off >= c_off_addr_t0);
  assign unused_ok   = ^{paddr[APB_A_W-1:8], BASE_ADDR};

  // Writes may only touch STATUS bit1; configuration is frozen while the
  // engine is busy; a START request while busy is refused.
  assign w_err = !w_mapped ||
                 (pwrite && ((w_is_status && ((w_wdata & ~32'h2) != 32'h0)) ||
                             (w_is_cfg && w_busy) ||
                             (w_is_ctrl && w_wdata[0] && w_busy)));

  assign w_commit   = (state_q == ST_ACCESS) && psel && penable;
  assign w_wr_ok    = w_commit && pwrite && !w_err;
  assign w_start    = w_wr_ok && w_is_ctrl && w_wdata[0];
  assign w_done_set = status_prev_q && !w_busy;
  assign w_done_clr = w_start || (w_wr_ok && w_is_status && w_wdata[1]);

  // Read mux
  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      c_off_status:   w_rdata = {30'd0, done_q, w_busy};
      c_off_addr_t0:  w_rdata = addr_t0_q;
      c_off_addr_t1:  w_rdata = addr_t1_q;
      c_off_addr_t2:  w_rdata = addr_t2_q;
      c_off_size_t0:  w_rdata = {6'd0, size_t0_q};
      c_off_size_t1:  w_rdata = {16'd0, size_t1_q};
      c_off_size_t2:  w_rdata = {1'b0, size_t2_q};
      c_off_zp:       w_rdata = {8'd0, zp_q};
      c_off_bias_t2:  w_rdata = bias_t2_q;
      c_off_scale_t2: w_rdata = scale_t2_q;
      c_off_shift_t2: w_rdata = {27'd0, shift_t2_q};
      default:        w_rdata = 32'h0;
    endcase
  end

  // APB state machine and registered response
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (psel && !penable) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (!psel)        state_d = ST_IDLE;
        else if (penable) state_d = ST_RESP;
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    pready_d  = w_commit;
    pslverr_d = w_commit && w_err;
    prdata_d  = (w_commit && !pwrite && !w_err) ? APB_A_W'(w_rdata) : '0;
  end

  // Register file, start pulse and sticky DONE
  always_comb begin
    addr_t0_d     = addr_t0_q;
    addr_t1_d     = addr_t1_q;
    addr_t2_d     = addr_t2_q;
    size_t0_d     = size_t0_q;
    size_t1_d     = size_t1_q;
    size_t2_d     = size_t2_q;
    zp_d          = zp_q;
    bias_t2_d     = bias_t2_q;
    scale_t2_d    = scale_t2_q;
    shift_t2_d    = shift_t2_q;
    control_d     = w_start;
    status_prev_d = w_busy;
    // A set in the same cycle as a clear wins, so a completion is never lost
    done_d        = w_done_set || (done_q && !w_done_clr);
    if (w_wr_ok) begin
      case (w_off)
        c_off_addr_t0:  addr_t0_d  = w_wdata;
        c_off_addr_t1:  addr_t1_d  = w_wdata;
        c_off_addr_t2:  addr_t2_d  = w_wdata;
        c_off_size_t0:  size_t0_d  = w_wdata[25:0];
        c_off_size_t1:  size_t1_d  = w_wdata[15:0];
        c_off_size_t2:  size_t2_d  = w_wdata[30:0];
        c_off_zp:       zp_d       = w_wdata[23:0];
        c_off_bias_t2:  bias_t2_d  = w_wdata;
        c_off_scale_t2: scale_t2_d = w_wdata;
        c_off_shift_t2: shift_t2_d = w_wdata[4:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      prdata_q      <= '0;
      control_q     <= 1'b0;
      done_q        <= 1'b0;
      status_prev_q <= 1'b0;
      addr_t0_q     <= '0;
      addr_t1_q     <= '0;
      addr_t2_q     <= '0;
      size_t0_q     <= '0;
      size_t1_q     <= '0;
      size_t2_q     <= '0;
      zp_q          <= '0;
      bias_t2_q     <= '0;
      scale_t2_q    <= '0;
      shift_t2_q    <= '0;
    end else begin
      state_q       <= state_d;
      pready_q      <= pready_d;
      pslverr_q     <= pslverr_d;
      prdata_q      <= prdata_d;
      control_q     <= control_d;
      done_q        <= done_d;
      status_prev_q <= status_prev_d;
      addr_t0_q     <= addr_t0_d;
      addr_t1_q     <= addr_t1_d;
      addr_t2_q     <= addr_t2_d;
      size_t0_q     <= size_t0_d;
      size_t1_q     <= size_t1_d;
      size_t2_q     <= size_t2_d;
      zp_q          <= zp_d;
      bias_t2_q     <= bias_t2_d;
      scale_t2_q    <= scale_t2_d;
      shift_t2_q    <= shift_t2_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

  assign csr.csr_control   = control_q;
  assign csr.csr_addr_t0   = addr_t0_q;
  assign csr.csr_addr_t1   = addr_t1_q;
  assign csr.csr_addr_t2   = addr_t2_q;
  assign csr.csr_addr_t0_0 = size_t0_q[9:0];
  assign csr.csr_addr_t0_1 = size_t0_q[19:10];
  assign csr.csr_addr_t0_2 = size_t0_q[25:20];
  assign csr.csr_addr_t1_0 = size_t1_q[4:0];
  assign csr.csr_addr_t1_1 = size_t1_q[9:5];
  assign csr.csr_addr_t1_2 = size_t1_q[15:10];
  assign csr.csr_addr_t2_0 = size_t2_q[9:0];
  assign csr.csr_addr_t2_1 = size_t2_q[19:10];
  assign csr.csr_addr_t2_2 = size_t2_q[30:20];
  assign csr.csr_zp_t0     = zp_q[7:0];
  assign csr.csr_zp_t1     = zp_q[15:8];
  assign csr.csr_zp_t2     = zp_q[23:16];
  assign csr.csr_bias_t2   = bias_t2_q;
  assign csr.csr_scale_t2  = scale_t2_q;
  assign csr.csr_shift_t2  = shift_t2_q;

endmodule
`default_nettype wire

// File: tb/tb_npu_csr_regs.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_npu_csr_regs                                               |
// | Brief  : Scoreboard bench for npu_csr_regs. The driver computes each   |
// |          expected response from a register-map model and queues it;    |
// |          a monitor pops and compares whenever pready is high.          |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module tb_npu_csr_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  CSR_BUS_SV csr_if ();

  npu_csr_regs #(.APB_A_W(32), .BASE_ADDR(32'h0)) dut (
    .clk     (clk),
    .rst     (rst),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .csr     (csr_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  rdata;
    logic         err;
    logic         start;
    logic [319:0] snap;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: register contents in readback format
  logic [31:0] m_cfg [10];
  bit          m_done;
  bit          busy;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Implemented bits per configuration word, index = (offset-8)/4
  function automatic logic [31:0] cfg_mask(input int idx);
    case (idx)
      3:       return 32'h03FF_FFFF;
      4:       return 32'h0000_FFFF;
      5:       return 32'h7FFF_FFFF;
      6:       return 32'h00FF_FFFF;
      9:       return 32'h0000_001F;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [319:0] model_snap();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[i*32 +: 32] = m_cfg[i];
    return s;
  endfunction

  function automatic logic [319:0] dut_snap();
    logic [319:0] s;
    s[0*32 +: 32] = csr_if.csr_addr_t0;
    s[1*32 +: 32] = csr_if.csr_addr_t1;
    s[2*32 +: 32] = csr_if.csr_addr_t2;
    s[3*32 +: 32] = {6'd0, csr_if.csr_addr_t0_2, csr_if.csr_addr_t0_1, csr_if.csr_addr_t0_0};
    s[4*32 +: 32] = {16'd0, csr_if.csr_addr_t1_2, csr_if.csr_addr_t1_1, csr_if.csr_addr_t1_0};
    s[5*32 +: 32] = {1'b0, csr_if.csr_addr_t2_2, csr_if.csr_addr_t2_1, csr_if.csr_addr_t2_0};
    s[6*32 +: 32] = {8'd0, csr_if.csr_zp_t2, csr_if.csr_zp_t1, csr_if.csr_zp_t0};
    s[7*32 +: 32] = csr_if.csr_bias_t2;
    s[8*32 +: 32] = csr_if.csr_scale_t2;
    s[9*32 +: 32] = {27'd0, csr_if.csr_shift_t2};
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 10; i++) m_cfg[i] = 32'h0;
    m_done = 1'b0;
  endtask

  // Apply one transfer to the model; busy_now is the busy level at commit,
  // done_rise models a busy 1->0 edge landing on the same commit.
  task automatic model_xfer(input logic wr, input logic [7:0] off, input logic [31:0] wd,
                            input bit busy_now, input bit done_rise, output exp_t e);
    int idx;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    e.start = 1'b0;
    if (off[1:0] != 2'b00 || off > 8'h2C) begin
      e.err = 1'b1;
    end else if (wr) begin
      if (off == 8'h00) begin
        if (wd[0] && busy_now) e.err = 1'b1;
        else if (wd[0]) begin e.start = 1'b1; m_done = 1'b0; end
      end else if (off == 8'h04) begin
        if ((wd & 32'hFFFF_FFFD) != 0) e.err = 1'b1;
        else if (wd[1]) m_done = 1'b0;
      end else begin
        idx = (int'(off) - 8) / 4;
        if (busy_now) e.err = 1'b1;
        else m_cfg[idx] = wd & cfg_mask(idx);
      end
    end else begin
      if (off == 8'h04) e.rdata = {30'd0, m_done, busy_now};
      else if (off >= 8'h08) e.rdata = m_cfg[(int'(off) - 8) / 4];
    end
    if (done_rise) m_done = 1'b1;
    e.snap = model_snap();
  endtask

  task automatic set_busy(input bit v);
    if (busy && !v) m_done = 1'b1;
    busy = v;
    csr_if.csr_status = v;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic apb(input logic wr, input logic [7:0] off, input logic [31:0] wd, input bit drop_busy);
    exp_t e;
    int   n;
    model_xfer(wr, off, wd, drop_busy ? 1'b0 : busy, drop_busy, e);
    sb_q.push_back(e);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = {24'($urandom), off};
    pwdata  = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    if (drop_busy) begin
      busy = 1'b0;
      csr_if.csr_status = 1'b0;
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!pready && n < 6);
    check("pready_latency", 320'(n), 320'd1);
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pready) begin
        check("pready_one_cycle", 320'(prev_rdy), 320'd0);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pready: got 1 expected 0 (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("prdata",      320'(prdata),             320'(e.rdata));
          check("pslverr",     320'(pslverr),            320'(e.err));
          check("csr_control", 320'(csr_if.csr_control), 320'(e.start));
          check("csr_fields",  dut_snap(),               e.snap);
        end
      end else begin
        check("csr_control_idle", 320'(csr_if.csr_control), 320'd0);
      end
      prev_rdy = pready;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  off;
    logic [31:0] wd;
    logic        wr;
    int          sel;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; busy = 1'b0; csr_if.csr_status = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready",  320'(pready),             320'd0);
    check("rst_pslverr", 320'(pslverr),            320'd0);
    check("rst_prdata",  320'(prdata),             320'd0);
    check("rst_control", 320'(csr_if.csr_control), 320'd0);
    check("rst_fields",  dut_snap(),               320'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Address register write/readback
    apb(1, 8'h08, 32'h1000_0040, 0);
    apb(0, 8'h08, 32'h0, 0);
    // Narrow size fields
    apb(1, 8'h18, 32'hFFFF_FFFF, 0);
    check("t1_row",   320'(csr_if.csr_addr_t1_0), 320'h1F);
    check("t1_col",   320'(csr_if.csr_addr_t1_1), 320'h1F);
    check("t1_depth", 320'(csr_if.csr_addr_t1_2), 320'h3F);
    apb(0, 8'h18, 32'h0, 0);
    // START, busy period, DONE set and W1C clear
    apb(1, 8'h00, 32'h1, 0);
    set_busy(1);
    repeat (8) @(posedge clk);
    #1;
    set_busy(0);
    apb(0, 8'h04, 32'h0, 0);
    apb(1, 8'h04, 32'h2, 0);
    apb(0, 8'h04, 32'h0, 0);
    // Busy lockout
    apb(1, 8'h20, 32'h0000_0011, 0);
    set_busy(1);
    apb(1, 8'h20, 32'h55, 0);
    apb(1, 8'h00, 32'h1, 0);
    apb(0, 8'h20, 32'h0, 0);
    apb(0, 8'h04, 32'h0, 0);
    // DONE set coincides with W1C: set wins
    apb(1, 8'h04, 32'h2, 1);
    apb(0, 8'h04, 32'h0, 0);
    apb(1, 8'h04, 32'h3, 0);
    // START clears DONE
    apb(1, 8'h00, 32'h1, 0);
    apb(0, 8'h04, 32'h0, 0);
    // Unmapped / misaligned, CONTROL read
    apb(0, 8'h30, 32'h0, 0);
    apb(0, 8'h06, 32'h0, 0);
    apb(0, 8'h2C, 32'h0, 0);
    apb(0, 8'h00, 32'h0, 0);
    apb(1, 8'h00, 32'h0, 0);

    // Reset in the middle of a write to BIAS_T2
    apb(1, 8'h24, 32'hDEAD_BEEF, 0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h1234_5678;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("abort_pready",  320'(pready),                320'd0);
    check("abort_pslverr", 320'(pslverr),               320'd0);
    check("abort_prdata",  320'(prdata),                320'd0);
    check("abort_bias",    320'(csr_if.csr_bias_t2),    320'd0);
    check("abort_fields",  dut_snap(),                  320'd0);
    apb(0, 8'h04, 32'h0, 0);

    // Randomised traffic
    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 11);
      if (sel == 0) begin
        set_busy(!busy);
      end else begin
        sel = $urandom_range(0, 15);
        if (sel < 12)       off = 8'(sel * 4);
        else if (sel == 12) off = 8'(8'h30 + 4 * $urandom_range(0, 3));
        else if (sel == 13) off = 8'(4 * $urandom_range(0, 11) + $urandom_range(1, 3));
        else if (sel == 14) off = 8'hFC;
        else                off = 8'h04;
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        if (off == 8'h04 && $urandom_range(0, 2) != 0) wd = 32'($urandom_range(0, 3));
        if (off == 8'h00 && $urandom_range(0, 1) != 0) wd = 32'($urandom_range(0, 1));
        apb(wr, off, wd, 0);
      end
    end
    set_busy(0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 320'(sb_q.size()), 320'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/npu_csr_regs.md
NPU_CSR_REGS -- requirements
Module: npu_csr_regs

Interface
REQ-001 SHALL have parameter APB_A_W, default 32, meaning APB address and data width (from npu_pkg).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, meaning block base address; registers decode on paddr[7:0] only.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports psel, penable, pwrite  input  1 each  APB3 control.
REQ-006 SHALL have ports paddr, pwdata  input  APB_A_W each  APB3 address and write data.
REQ-007 SHALL have ports prdata  output  APB_A_W, pready  output  1, pslverr  output  1  APB3 response.
REQ-008 SHALL have port csr  CSR_BUS_SV.Slave  -  drives all configuration fields and csr_control; samples csr_status.

Function
REQ-009 Register map (byte offsets), all word-aligned:
- 0x00 CONTROL (WO): bit0 START.
- 0x04 STATUS (RO/W1C): bit0 BUSY = csr_status; bit1 DONE, sticky.
- 0x08/0x0C/0x10 ADDR_T0/T1/T2 (RW): full 32 bits.
- 0x14 SIZE_T0 (RW): [9:0] row, [19:10] col, [25:20] depth.
- 0x18 SIZE_T1 (RW): [4:0] row, [9:5] col, [15:10] depth.
- 0x1C SIZE_T2 (RW): [9:0] row, [19:10] col, [30:20] depth.
- 0x20 ZP (RW): [7:0] t0, [15:8] t1, [23:16] t2, signed.
- 0x24 BIAS_T2, 0x28 SCALE_T2 (RW): full 32 bits, signed.
- 0x2C SHIFT_T2 (RW): [4:0].
REQ-010 SHALL read unimplemented bits as 0; writes to them SHALL be discarded.
REQ-011 APB FSM SHALL have states IDLE, ACCESS, RESP: IDLE->ACCESS on psel&!penable; ACCESS->RESP on psel&penable; RESP->IDLE unconditionally.
REQ-012 pready SHALL be high only in RESP, exactly one cycle; every transfer has one wait state.
REQ-013 prdata and pslverr SHALL be registered on ACCESS->RESP and valid only while pready=1; prdata SHALL be 0 otherwise.
REQ-014 Write SHALL commit on the ACCESS->RESP edge; the new value is visible on csr outputs the cycle pready is high.
REQ-015 pslverr=1 SHALL be returned for: unmapped offset (>0x2C or paddr[1:0]!=0); write to STATUS except bit1; any write to 0x08..0x2C while BUSY=1; START write while BUSY=1. Erroring writes SHALL change no state.
REQ-016 Reads of CONTROL SHALL return 0 with pslverr=0.
REQ-017 A valid START=1 write SHALL pulse csr_control high for exactly one cycle, the cycle after commit; START=0 write is a no-op.
REQ-018 DONE SHALL set on a 1->0 transition of csr_status (registered previous value); write 1 to STATUS bit1 SHALL clear it; simultaneous set and clear SHALL leave DONE=1.
REQ-019 A valid START write SHALL also clear DONE.
REQ-020 psel dropping in ACCESS SHALL return FSM to IDLE with no commit and no pready.
REQ-021 csr_status SHALL be treated as synchronous to clk; no synchronizer.

Reset
REQ-022 On rst=1 at a clk edge: FSM=IDLE, pready=0, pslverr=0, prdata=0, csr_control=0, DONE=0, all config registers=0, status edge register=0.
REQ-023 Reset mid-transfer SHALL abort it with no commit and no pready; the master must restart the transfer.

Verification
REQ-024 Write 0x1000_0040 to 0x08, read 0x08 -> pready on 3rd cycle, prdata=0x1000_0040, csr_addr_t0=0x1000_0040, pslverr=0.
REQ-025 Write 0xFFFF_FFFF to 0x18 -> csr_addr_t1_0=5'h1F, csr_addr_t1_1=5'h1F, csr_addr_t1_2=6'h3F; readback 0x0000_FFFF.
REQ-026 Write 1 to 0x00 with csr_status=0 -> csr_control high one cycle; then drive csr_status 1 for 10 cycles then 0 -> STATUS reads 0x2; write 0x2 to 0x04 -> STATUS reads 0x0.
REQ-027 With csr_status=1, write 0x55 to 0x20 and 1 to 0x00 -> pslverr=1 both, ZP unchanged, no csr_control pulse.
REQ-028 Read 0x30 and 0x06 -> pslverr=1, prdata=0; next valid read 0x2C returns pslverr=0.
REQ-029 Assert rst during ACCESS of a write to 0x24 -> no pready, csr_bias_t2=0, all outputs at reset values.
